// File: rtl/memory_cycle_pkg.sv
// Shared encodings for the memory stage: access-size codes, result-select codes, FSM states.
package memory_cycle_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_LOAD = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Size codes the stage actually implements; anything else is treated as no access.
  function automatic logic f3_supported(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_cycle_load_align.sv
// Selects the addressed byte/half/word out of a bus word and sign- or zero-extends it.
module load_align
  import memory_cycle_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(rdata >> {offset, 3'b000});
    half_sel = 16'(rdata >> {offset[1], 4'b0000});
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h000000, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_cycle.sv
// Pipeline memory stage: data-bus handshake with wait states, store strobes, load extraction, MEM/WB register.
module memory_cycle
  import memory_cycle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [XLEN-1:0]   ALU_ResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [2:0]        Funct3M,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [REG_AW-1:0] RD_W,
  output logic [XLEN-1:0]   ALU_ResultW,
  output logic [XLEN-1:0]   ReadDataW,
  output logic [XLEN-1:0]   PCPlus4W,
  output logic              MisalignW,
  output logic              StallM
);

  mem_state_e      state, state_nxt;
  logic [1:0]      off;
  logic            access, mis, go;
  logic            req_c, stall_c;
  logic [XLEN-1:0] load_data;

  assign off    = ALU_ResultM[1:0];
  assign access = (MemWriteM || (ResultSrcM == RS_LOAD)) && f3_supported(Funct3M);
  assign mis    = access && f3_misaligned(Funct3M, off);
  assign go     = access && !mis;

  // Next state and bus request; WAIT relies on the frozen E/M register to keep the request stable.
  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        req_c = go;
        if (go && !dmem_ready) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        req_c = 1'b1;
        if (dmem_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign stall_c   = req_c && !dmem_ready;
  assign dmem_req  = req_c && rst;
  assign StallM    = stall_c && rst;
  assign dmem_we   = MemWriteM;
  assign dmem_addr = {ALU_ResultM[XLEN-1:2], 2'b00};

  // Store lane placement.
  always_comb begin
    dmem_wstrb = 4'b0000;
    dmem_wdata = WriteDataM;
    if (MemWriteM && access) begin
      case (Funct3M[1:0])
        2'b00: begin
          dmem_wstrb = 4'(4'b0001 << off);
          dmem_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          dmem_wstrb = 4'(4'b0011 << off);
          dmem_wdata = {2{WriteDataM[15:0]}};
        end
        default: dmem_wstrb = 4'b1111;
      endcase
    end
  end

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (off),
    .funct3 (Funct3M),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // MEM/WB register: bubble while stalled, otherwise capture the stage outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 2'b00;
      RD_W        <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      PCPlus4W    <= '0;
      MisalignW   <= 1'b0;
    end else if (stall_c) begin
      RegWriteW <= 1'b0;
      MisalignW <= 1'b0;
    end else begin
      RegWriteW   <= RegWriteM && !mis;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= load_data;
      PCPlus4W    <= PCPlus4M;
      MisalignW   <= mis;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: loads, stores, wait states, misalignment and reset mid-access.
module tb_memory_cycle;

  logic        clk, rst;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;
  logic [2:0]  Funct3M;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        RegWriteW, MisalignW, StallM;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W;

  int total = 0;
  int bad   = 0;

  memory_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
    .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .Funct3M(Funct3M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W), .ALU_ResultW(ALU_ResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .MisalignW(MisalignW), .StallM(StallM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic rw, input logic mw, input logic [1:0] rs, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [2:0] f3,
                       input logic rdy, input logic [31:0] rdata);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
    ALU_ResultM = alu; WriteDataM = wd; PCPlus4M = alu + 32'h1000; Funct3M = f3;
    dmem_ready = rdy; dmem_rdata = rdata;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'b01, 5'd3, 32'h100, 32'h0, 3'b010, 1'b0, 32'h0);
    #3;
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", dmem_req); end
    total++; if (StallM !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", StallM); end
    total++; if ({RegWriteW, MisalignW, RD_W, ALU_ResultW, ReadDataW} !== '0) begin
      bad++; $display("FAIL reset_w got=%b/%b/%h/%h/%h want=0", RegWriteW, MisalignW, RD_W, ALU_ResultW, ReadDataW); end
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h0);
    rst = 1'b1;
  endtask

  task automatic test_loads;
    // LB at offset 3 of 0x80FF1234 picks 0x80
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 5'd5, 32'h103, 32'h0, 3'b000, 1'b1, 32'h80FF1234);
    #1;
    total++; if (dmem_req !== 1'b1 || StallM !== 1'b0) begin bad++; $display("FAIL lb_req got=%b/%b want=1/0", dmem_req, StallM); end
    total++; if (dmem_addr !== 32'h100 || dmem_we !== 1'b0) begin bad++; $display("FAIL lb_addr got=%h/%b want=00000100/0", dmem_addr, dmem_we); end
    @(posedge clk); #1;
    total++; if (ReadDataW !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got=%h want=ffffff80", ReadDataW); end
    total++; if (RegWriteW !== 1'b1 || RD_W !== 5'd5 || ResultSrcW !== 2'b01) begin
      bad++; $display("FAIL lb_ctrl got=%b/%0d/%b want=1/5/01", RegWriteW, RD_W, ResultSrcW); end
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 5'd6, 32'h102, 32'h0, 3'b101, 1'b1, 32'h80FF1234);
    @(posedge clk); #1;
    total++; if (ReadDataW !== 32'h000080FF) begin bad++; $display("FAIL lhu_data got=%h want=000080ff", ReadDataW); end
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 5'd6, 32'h102, 32'h0, 3'b001, 1'b1, 32'h80FF1234);
    @(posedge clk); #1;
    total++; if (ReadDataW !== 32'hFFFF80FF) begin bad++; $display("FAIL lh_data got=%h want=ffff80ff", ReadDataW); end
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 5'd7, 32'h101, 32'h0, 3'b100, 1'b1, 32'h80FF1234);
    @(posedge clk); #1;
    total++; if (ReadDataW !== 32'h00000012) begin bad++; $display("FAIL lbu_data got=%h want=00000012", ReadDataW); end
  endtask

  task automatic test_stores;
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 5'd0, 32'h202, 32'h0000BEEF, 3'b001, 1'b1, 32'h0);
    #1;
    total++; if (dmem_wstrb !== 4'b1100 || dmem_wdata !== 32'hBEEFBEEF) begin
      bad++; $display("FAIL sh_lanes got=%b/%h want=1100/beefbeef", dmem_wstrb, dmem_wdata); end
    total++; if (dmem_addr !== 32'h200 || dmem_we !== 1'b1 || dmem_req !== 1'b1) begin
      bad++; $display("FAIL sh_bus got=%h/%b/%b want=00000200/1/1", dmem_addr, dmem_we, dmem_req); end
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 5'd0, 32'h301, 32'h12345678, 3'b000, 1'b1, 32'h0);
    #1;
    total++; if (dmem_wstrb !== 4'b0010 || dmem_wdata !== 32'h78787878) begin
      bad++; $display("FAIL sb_lanes got=%b/%h want=0010/78787878", dmem_wstrb, dmem_wdata); end
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 5'd0, 32'h40, 32'hCAFEF00D, 3'b010, 1'b1, 32'h0);
    #1;
    total++; if (dmem_wstrb !== 4'b1111 || dmem_wdata !== 32'hCAFEF00D) begin
      bad++; $display("FAIL sw_lanes got=%b/%h want=1111/cafef00d", dmem_wstrb, dmem_wdata); end
    @(posedge clk); #1;
    total++; if (RegWriteW !== 1'b0 || MisalignW !== 1'b0) begin bad++; $display("FAIL sw_w got=%b/%b want=0/0", RegWriteW, MisalignW); end
  endtask

  task automatic test_wait_states;
    int stalls = 0;
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 5'd9, 32'h100, 32'h0, 3'b010, 1'b0, 32'h11223344);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (StallM === 1'b1) stalls++;
      total++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_we !== 1'b0) begin
        bad++; $display("FAIL wait_bus_%0d got=%b/%h/%b want=1/00000100/0", i, dmem_req, dmem_addr, dmem_we); end
      @(posedge clk); #1;
      total++; if (RegWriteW !== 1'b0) begin bad++; $display("FAIL wait_bubble_%0d got=%b want=0", i, RegWriteW); end
      @(negedge clk);
    end
    total++; if (stalls !== 3) begin bad++; $display("FAIL wait_stall_cycles got=%0d want=3", stalls); end
    dmem_ready = 1'b1;
    #1;
    total++; if (StallM !== 1'b0 || dmem_req !== 1'b1) begin bad++; $display("FAIL wait_done_bus got=%b/%b want=0/1", StallM, dmem_req); end
    @(posedge clk); #1;
    total++; if (ReadDataW !== 32'h11223344 || RegWriteW !== 1'b1 || RD_W !== 5'd9) begin
      bad++; $display("FAIL wait_done_w got=%h/%b/%0d want=11223344/1/9", ReadDataW, RegWriteW, RD_W); end
  endtask

  task automatic test_misalign;
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 5'd4, 32'h101, 32'h0, 3'b010, 1'b0, 32'h0);
    #1;
    total++; if (dmem_req !== 1'b0 || StallM !== 1'b0) begin bad++; $display("FAIL mis_lw_bus got=%b/%b want=0/0", dmem_req, StallM); end
    @(posedge clk); #1;
    total++; if (MisalignW !== 1'b1 || RegWriteW !== 1'b0) begin bad++; $display("FAIL mis_lw_w got=%b/%b want=1/0", MisalignW, RegWriteW); end
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 5'd0, 32'h203, 32'h0, 3'b001, 1'b0, 32'h0);
    #1;
    total++; if (dmem_req !== 1'b0 || StallM !== 1'b0) begin bad++; $display("FAIL mis_sh_bus got=%b/%b want=0/0", dmem_req, StallM); end
    @(posedge clk); #1;
    total++; if (MisalignW !== 1'b1) begin bad++; $display("FAIL mis_sh_w got=%b want=1", MisalignW); end
  endtask

  task automatic test_passthrough;
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 5'd8, 32'h104, 32'h0, 3'b011, 1'b0, 32'h0);
    #1;
    total++; if (dmem_req !== 1'b0 || StallM !== 1'b0) begin bad++; $display("FAIL unsup_bus got=%b/%b want=0/0", dmem_req, StallM); end
    @(posedge clk); #1;
    total++; if (RegWriteW !== 1'b1 || MisalignW !== 1'b0) begin bad++; $display("FAIL unsup_w got=%b/%b want=1/0", RegWriteW, MisalignW); end
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 5'd10, 32'h55, 32'h0, 3'b000, 1'b0, 32'h0);
    #1;
    total++; if (dmem_req !== 1'b0 || StallM !== 1'b0) begin bad++; $display("FAIL add_bus got=%b/%b want=0/0", dmem_req, StallM); end
    @(posedge clk); #1;
    total++; if (RegWriteW !== 1'b1 || ALU_ResultW !== 32'h55 || PCPlus4W !== 32'h1055 || RD_W !== 5'd10) begin
      bad++; $display("FAIL add_w got=%b/%h/%h/%0d want=1/00000055/00001055/10", RegWriteW, ALU_ResultW, PCPlus4W, RD_W); end
  endtask

  task automatic test_reset_in_wait;
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 5'd11, 32'h180, 32'h0, 3'b010, 1'b0, 32'hDEADBEEF);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    total++; if (dmem_req !== 1'b0 || StallM !== 1'b0) begin bad++; $display("FAIL rstwait_bus got=%b/%b want=0/0", dmem_req, StallM); end
    total++; if ({RegWriteW, RD_W, ALU_ResultW, ReadDataW, PCPlus4W} !== '0) begin
      bad++; $display("FAIL rstwait_w got=%b/%0d/%h/%h want=0", RegWriteW, RD_W, ALU_ResultW, ReadDataW); end
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 5'd12, 32'h77, 32'h0, 3'b000, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    total++; if (dmem_req !== 1'b0 || StallM !== 1'b0) begin bad++; $display("FAIL rstwait_idle got=%b/%b want=0/0", dmem_req, StallM); end
    @(posedge clk); #1;
    total++; if (RegWriteW !== 1'b1 || ALU_ResultW !== 32'h77 || RD_W !== 5'd12) begin
      bad++; $display("FAIL rstwait_add got=%b/%h/%0d want=1/00000077/12", RegWriteW, ALU_ResultW, RD_W); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_wait_states();
    test_misalign();
    test_passthrough();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
